seven_seg_scan_ctrl: RTL and testbench

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 107 ++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one GUARD (dark) cycle, then REFRESH_DIV SHOW cycles per digit.
// Optional macro LEADING_ZERO_BLANK_EN keeps leading-zero digits dark during their SHOW slot.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic                    load_ready,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic {GUARD, SHOW} state_t;

    state_t                         state;
    logic                           started;
    logic                           pending;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W-1:0]               next_idx;
    logic [CNT_W-1:0]               cnt;
    logic [NUM_DIGITS-1:0][3:0]     display;
    logic [NUM_DIGITS-1:0][3:0]     shadow;
    logic [NUM_DIGITS-1:0][3:0]     next_display;
    logic [NUM_DIGITS-1:0]          show_mask;

    assign next_idx     = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    // A pending load lands only on the wrap back to digit 0, so a frame never mixes old and new data.
    assign next_display = (next_idx == '0 && pending) ? shadow : display;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_above;

    always_comb begin
        logic acc;
        acc        = 1'b1;
        zero_above = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            acc           = acc & (display[k] == 4'd0);
            zero_above[k] = acc;
        end
    end

    assign show_mask = (idx != '0 && zero_above[idx]) ? '0 : NUM_DIGITS'(1) << idx;
`else
    assign show_mask = NUM_DIGITS'(1) << idx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= GUARD;
            started     <= 1'b0;
            pending     <= 1'b0;
            idx         <= '0;
            cnt         <= '0;
            display     <= '0;
            shadow      <= '0;
            load_ready  <= 1'b1;
            bcd_out     <= 4'd0;
            digit_en    <= '0;
            frame_start <= 1'b0;
        end else begin
            if (load && load_ready) begin
                shadow  <= digits_in;
                pending <= 1'b1;
            end
            // Stays low for the commit cycle itself; rises one cycle after pending clears.
            load_ready  <= !(load && load_ready) && !pending;
            frame_start <= 1'b0;

            if (!started) begin
                // First cycle out of reset is the GUARD slot of digit 0.
                started     <= 1'b1;
                frame_start <= 1'b1;
            end else begin
                case (state)
                    GUARD: begin
                        state    <= SHOW;
                        cnt      <= '0;
                        digit_en <= show_mask;
                    end
                    SHOW: begin
                        if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                            state    <= GUARD;
                            digit_en <= '0;
                            idx      <= next_idx;
                            display  <= next_display;
                            bcd_out  <= next_display[next_idx];
                            if (next_idx == '0) begin
                                frame_start <= 1'b1;
                                if (pending) pending <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= GUARD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=3): directed table, corner sequences,
// and random traffic against a frame-position reference model.
module tb_seven_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 3;
    localparam int F  = ND * (RD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [15:0]   digits_in;
    logic          load_ready;
    logic [3:0]    bcd_out;
    logic [ND-1:0] digit_en;
    logic          frame_start;

    seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
        .load_ready(load_ready), .bcd_out(bcd_out), .digit_en(digit_en),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int misc = 0;

    // Model: pos = clock index within the frame, -1 for the cycle right after a reset edge.
    int          pos;
    logic [15:0] m_disp, m_shadow;
    logic        m_pend, m_lr;

    task automatic model_edge(input logic r, input logic l, input logic [15:0] d);
        logic acc;
        if (r) begin
            pos = -1; m_disp = '0; m_shadow = '0; m_pend = 1'b0; m_lr = 1'b1;
            return;
        end
        acc  = l && m_lr;
        m_lr = !acc && !m_pend;
        pos  = (pos + 1) % F;
        if (pos == 0 && m_pend) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        if (acc) begin
            m_shadow = d;
            m_pend   = 1'b1;
        end
    endtask

    function automatic logic [ND-1:0] exp_en();
        int slot, phase;
        if (pos < 0) return '0;
        slot  = pos / (RD + 1);
        phase = pos % (RD + 1);
        if (phase == 0) return '0;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_disp >> (4 * slot)) == 16'd0) return '0;
`endif
        return ND'(1) << slot;
    endfunction

    function automatic logic [3:0] exp_bcd();
        if (pos < 0) return 4'd0;
        return m_disp[4 * (pos / (RD + 1)) +: 4];
    endfunction

    task automatic check(input string name, input logic [ND-1:0] en, input logic [3:0] bcd,
                         input logic fs, input logic lr);
        vecs++;
        if (digit_en !== en || bcd_out !== bcd || frame_start !== fs || load_ready !== lr) begin
            misc++;
            $display("FAIL %s t=%0t: got en=%b bcd=%h fs=%b lr=%b, want en=%b bcd=%h fs=%b lr=%b",
                     name, $time, digit_en, bcd_out, frame_start, load_ready, en, bcd, fs, lr);
        end
    endtask

    task automatic check_model(input string name);
        check(name, exp_en(), exp_bcd(), pos == 0, m_lr);
    endtask

    task automatic cyc(input logic r, input logic l, input logic [15:0] d);
        rst = r; load = l; digits_in = d;
        @(posedge clk);
        model_edge(r, l, d);
        @(negedge clk);
    endtask

    task automatic run_to(input int target, input string name);
        for (int k = 0; k < F + 2 && pos != target; k++) begin
            check_model(name);
            cyc(1'b0, 1'b0, 16'h0);
        end
        vecs++;
        if (pos != target) begin
            misc++;
            $display("FAIL %s timeout: got pos=%0d, want pos=%0d", name, pos, target);
        end
    endtask

    typedef struct {
        logic          ld;
        logic [15:0]   d;
        logic [ND-1:0] en;
        logic [3:0]    bcd;
        logic          fs;
        logic          lr;
    } vec_t;

    vec_t tbl[25];

`ifdef LEADING_ZERO_BLANK_EN
    task automatic lzb_frame(input logic [3:0][ND-1:0] want, input string name);
        for (int k = 0; k < F; k++) begin
            if (pos % (RD + 1) == 1) check(name, want[pos / (RD + 1)], exp_bcd(), 1'b0, m_lr);
            else check_model(name);
            cyc(1'b0, 1'b0, 16'h0);
        end
    endtask
`endif

    initial begin
        // Cycle-by-cycle expectations after reset release: load 1234 at 5, ignored 9999 at 7.
        tbl[0]  = '{1'b0, 16'h0,    4'b0000, 4'h0, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 16'h0,    4'b0001, 4'h0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 16'h0,    4'b0001, 4'h0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 16'h0,    4'b0001, 4'h0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 16'h0,    4'b0000, 4'h0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 16'h1234, 4'b0010, 4'h0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 16'h0,    4'b0010, 4'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'h9999, 4'b0010, 4'h0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 16'h0,    4'b0000, 4'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'h0,    4'b0100, 4'h0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 16'h0,    4'b0100, 4'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 16'h0,    4'b0100, 4'h0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 16'h0,    4'b0000, 4'h0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 16'h0,    4'b1000, 4'h0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 16'h0,    4'b1000, 4'h0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 16'h0,    4'b1000, 4'h0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 16'h0,    4'b0000, 4'h4, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 16'h0,    4'b0001, 4'h4, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 16'h0,    4'b0001, 4'h4, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 16'h0,    4'b0001, 4'h4, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 16'h0,    4'b0000, 4'h3, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 16'h0,    4'b0010, 4'h3, 1'b0, 1'b1};
        tbl[22] = '{1'b0, 16'h0,    4'b0010, 4'h3, 1'b0, 1'b1};
        tbl[23] = '{1'b0, 16'h0,    4'b0010, 4'h3, 1'b0, 1'b1};
        tbl[24] = '{1'b0, 16'h0,    4'b0000, 4'h2, 1'b0, 1'b1};

        rst = 1'b1; load = 1'b0; digits_in = 16'h0;
        pos = -1; m_disp = '0; m_shadow = '0; m_pend = 1'b0; m_lr = 1'b1;
        cyc(1'b1, 1'b1, 16'hFFFF);
        cyc(1'b1, 1'b0, 16'h0);
        check("reset_outputs", '0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0);

`ifndef LEADING_ZERO_BLANK_EN
        for (int i = 0; i < 25; i++) begin
            check($sformatf("table[%0d]", i), tbl[i].en, tbl[i].bcd, tbl[i].fs, tbl[i].lr);
            cyc(1'b0, tbl[i].ld, tbl[i].d);
        end
`else
        cyc(1'b0, 1'b1, 16'h0050);
        run_to(0, "lzb_commit_0050");
        lzb_frame({4'b0000, 4'b0000, 4'b0010, 4'b0001}, "lzb_0050");
        cyc(1'b0, 1'b1, 16'h0000);
        run_to(0, "lzb_commit_0000");
        lzb_frame({4'b0000, 4'b0000, 4'b0000, 4'b0001}, "lzb_0000");
`endif

        // Load held across the commit edge: ignored twice, accepted the cycle after.
        run_to(2, "hold_sync");
        cyc(1'b0, 1'b1, 16'h5678);
        run_to(F - 1, "hold_to_end");
        for (int k = 0; k < 3; k++) begin
            check_model("hold_across_commit");
            cyc(1'b0, 1'b1, 16'h4321);
        end
        run_to(0, "hold_next_frame");
        check("hold_applied", 4'b0000, 4'h1, 1'b1, 1'b0);

        // Reset mid-SHOW of digit 2 with a load pending.
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 16'h7777);
        run_to(10, "rst_mid_sync");
        check_model("rst_mid_before");
        cyc(1'b1, 1'b0, 16'h0);
        check("rst_mid_reset", '0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0);
        check("rst_mid_guard", '0, 4'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 16'h0);

        for (int k = 0; k < 800; k++) begin
            logic        r, l;
            logic [15:0] d;
            r = ($urandom_range(0, 199) == 0);
            l = ($urandom_range(0, 5) == 0);
            d = 16'($urandom);
            check_model("random");
            cyc(r, l, d);
        end
        check_model("random_last");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
        $finish;
    end
endmodule
